// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared types and constants for the SD/eMMC command-line receiver and CRC7 logic.
//   Exports: SD_CMD_FRAME_W, SD_CMD_CRC_BITS, CRC7_POLY, state_t, frame_t, crc7_step().
package sd_cmd_pkg;
   localparam int SD_CMD_FRAME_W = 48;
   localparam int SD_CMD_CRC_BITS = 40;
   localparam logic [6:0] CRC7_POLY = 7'h09;
   typedef enum logic [1:0] {IDLE, HUNT, RECV} state_t;
   typedef struct packed {
      logic dir;
      logic [5:0] index;
      logic [31:0] arg;
      logic [6:0] crc;
      logic crc_err;
      logic end_err;
      logic dir_err;
   } frame_t;
   // One MSB-first step of the x^7+x^3+1 CRC.
   function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
      return {crc[5:0], 1'b0} ^ ((din ^ crc[6]) ? CRC7_POLY : 7'h00);
   endfunction
endpackage

// File: rtl/sd_crc7_ser.sv
// sd_crc7_ser: serial MSB-first CRC7 (x^7+x^3+1).
//   clk, rst (async high) | clr: restart from zero | en: absorb din | din: serial bit | crc: 7-bit remainder
module sd_crc7_ser
   import sd_cmd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       din,
   output logic [6:0] crc
);
   // clr and en together restart the remainder and absorb din in the same cycle.
   always_ff @(posedge clk or posedge rst)
      if (rst)
         crc <= '0;
      else if (clr || en)
         crc <= en ? crc7_step(clr ? 7'h00 : crc, din) : 7'h00;
endmodule

// File: rtl/sd_cmd_rx.sv
// sd_cmd_rx: card-side SD command receiver; frames 48-bit commands, checks them, buffers one, and times out Ncr.
//   clk, rst (async high), en: enable | cmd_i: CMD line | tout_arm: start timeout window
//   frm_valid/frm_ready: one-entry output handshake | frm_dir, frm_index, frm_arg, frm_crc_rx: decoded fields
//   frm_crc_err, frm_end_err, frm_dir_err: frame errors | tout_err, ovr_err: one-cycle pulses | busy: in RECV
module sd_cmd_rx
   import sd_cmd_pkg::*;
#(
   parameter int TOUT_CYCLES  = 64,
   parameter bit CHECK_TX_BIT = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        cmd_i,
   input  logic        tout_arm,
   output logic        frm_valid,
   input  logic        frm_ready,
   output logic        frm_dir,
   output logic [5:0]  frm_index,
   output logic [31:0] frm_arg,
   output logic [6:0]  frm_crc_rx,
   output logic        frm_crc_err,
   output logic        frm_end_err,
   output logic        frm_dir_err,
   output logic        tout_err,
   output logic        ovr_err,
   output logic        busy
);
   state_t state, nxt;
   logic [5:0] bitcnt;
   logic [45:0] sh;
   logic [6:0] crc;
   logic [9:0] tcnt;
   logic armed, done, crc_clr, crc_en;
   frame_t rx, buf_q;
   // bitcnt names the frame bit being sampled now: bit (47 - bitcnt).
   assign done = en && state == RECV && bitcnt == 6'(SD_CMD_FRAME_W - 1);
   assign crc_clr = state != RECV;
   assign crc_en = (state == HUNT && !cmd_i) || (state == RECV && bitcnt < 6'(SD_CMD_CRC_BITS));
   sd_crc7_ser u_crc (
      .clk (clk),
      .rst (rst),
      .clr (crc_clr),
      .en  (crc_en),
      .din (cmd_i),
      .crc (crc)
   );
   always_ff @(posedge clk or posedge rst)
      if (rst)
         state <= IDLE;
      else
         state <= nxt;
   always_comb begin
      nxt = state;
      case (state)
         IDLE:    nxt = HUNT;
         HUNT:    nxt = cmd_i ? HUNT : RECV;
         RECV:    nxt = done ? HUNT : RECV;
         default: nxt = IDLE;
      endcase
      if (!en) nxt = IDLE;
   end
   // At the end bit, sh holds frame bits 46..1 and cmd_i is bit 0.
   always_comb begin
      rx = '0;
      rx.dir = sh[45];
      rx.index = sh[44:39];
      rx.arg = sh[38:7];
      rx.crc = sh[6:0];
      rx.crc_err = crc != sh[6:0];
      rx.end_err = !cmd_i;
      rx.dir_err = CHECK_TX_BIT && !sh[45];
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         bitcnt <= '0;
         sh <= '0;
      end else begin
         bitcnt <= state == RECV ? bitcnt + 6'd1 : 6'd1;
         if (state == RECV) sh <= {sh[44:0], cmd_i};
      end
   // A completing frame wins the slot if it is empty or being drained this cycle.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         buf_q <= '0;
         frm_valid <= 1'b0;
         ovr_err <= 1'b0;
      end else begin
         ovr_err <= done && frm_valid && !frm_ready;
         if (done && (!frm_valid || frm_ready)) begin
            buf_q <= rx;
            frm_valid <= 1'b1;
         end else if (frm_ready) begin
            frm_valid <= 1'b0;
         end
      end
   // The counter only moves in HUNT; the expiry pulse comes one cycle after it reaches zero.
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         armed <= 1'b0;
         tcnt <= '0;
         tout_err <= 1'b0;
      end else begin
         tout_err <= 1'b0;
         if (!en || (state == HUNT && !cmd_i)) begin
            armed <= 1'b0;
         end else if (tout_arm && state != RECV) begin
            armed <= 1'b1;
            tcnt <= 10'(TOUT_CYCLES);
         end else if (armed && tcnt == 10'd0) begin
            armed <= 1'b0;
            tout_err <= 1'b1;
         end else if (armed && state == HUNT) begin
            tcnt <= tcnt - 10'd1;
         end
      end
   assign frm_dir = buf_q.dir;
   assign frm_index = buf_q.index;
   assign frm_arg = buf_q.arg;
   assign frm_crc_rx = buf_q.crc;
   assign frm_crc_err = buf_q.crc_err;
   assign frm_end_err = buf_q.end_err;
   assign frm_dir_err = buf_q.dir_err;
   assign busy = state == RECV;
endmodule

// File: tb/tb_sd_cmd_rx.sv
// tb_sd_cmd_rx: table-driven and directed checks of the SD command receiver.
module tb_sd_cmd_rx;
   logic clk = 1'b0, rst = 1'b1, en = 1'b1, cmd_i = 1'b1, tout_arm = 1'b0, frm_ready = 1'b0;
   logic frm_valid, frm_dir, frm_crc_err, frm_end_err, frm_dir_err, tout_err, ovr_err, busy;
   logic [5:0] frm_index;
   logic [31:0] frm_arg;
   logic [6:0] frm_crc_rx;
   int checks = 0, errors = 0, cyc = 0, ovr_cnt = 0, tout_cnt = 0;
   logic [48:0] got[$];
   typedef struct {
      logic [47:0] f;
      logic dir;
      logic [5:0] idx;
      logic [31:0] arg;
      logic [6:0] crc;
      logic ce, ee, de;
   } vec_t;
   vec_t vecs[6];

   sd_cmd_rx #(.TOUT_CYCLES(64), .CHECK_TX_BIT(1'b1)) dut (
      .clk(clk), .rst(rst), .en(en), .cmd_i(cmd_i), .tout_arm(tout_arm),
      .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_dir(frm_dir), .frm_index(frm_index),
      .frm_arg(frm_arg), .frm_crc_rx(frm_crc_rx), .frm_crc_err(frm_crc_err),
      .frm_end_err(frm_end_err), .frm_dir_err(frm_dir_err), .tout_err(tout_err),
      .ovr_err(ovr_err), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [48:0] cur();
      return {frm_dir, frm_index, frm_arg, frm_crc_rx, frm_crc_err, frm_end_err, frm_dir_err};
   endfunction

   function automatic logic [48:0] pk(input vec_t v);
      return {v.dir, v.idx, v.arg, v.crc, v.ce, v.ee, v.de};
   endfunction

   always @(negedge clk) begin
      #1;
      if (frm_valid && frm_ready) got.push_back(cur());
      if (ovr_err) ovr_cnt++;
      if (tout_err) tout_cnt++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_bits(input logic [47:0] f, input int n);
      for (int i = 47; i > 47 - n; i--) begin
         @(negedge clk);
         cmd_i = f[i];
      end
   endtask

   task automatic send(input logic [47:0] f);
      send_bits(f, 48);
   endtask

   task automatic chk_only(input string name, input vec_t v);
      chk({name, "_count"}, 64'(got.size()), 64'd1);
      chk({name, "_frame"}, got.size() > 0 ? got[0] : 49'h0, pk(v));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int a, n, base;
      logic seen;
      vecs[0] = '{48'h400000000095, 1'b1, 6'd0,  32'h0,     7'h4A, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{48'h48000001AA87, 1'b1, 6'd8,  32'h1AA,   7'h43, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{48'h510000000055, 1'b1, 6'd17, 32'h0,     7'h2A, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{48'h400000000097, 1'b1, 6'd0,  32'h0,     7'h4B, 1'b1, 1'b0, 1'b0};
      vecs[4] = '{48'h400000000094, 1'b1, 6'd0,  32'h0,     7'h4A, 1'b0, 1'b1, 1'b0};
      vecs[5] = '{48'h000000000001, 1'b0, 6'd0,  32'h0,     7'h00, 1'b0, 1'b0, 1'b1};

      repeat (2) @(negedge clk);
      chk("reset", {frm_valid, cur(), tout_err, ovr_err, busy}, 64'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);

      // back-to-back table frames, always accepted
      frm_ready = 1'b1;
      got.delete();
      for (int i = 0; i < 6; i++) send(vecs[i].f);
      @(negedge clk);
      cmd_i = 1'b1;
      repeat (4) @(negedge clk);
      chk("tbl_count", 64'(got.size()), 64'd6);
      for (int i = 0; i < 6; i++)
         chk($sformatf("tbl%0d", i), i < got.size() ? got[i] : 49'h0, pk(vecs[i]));

      // latency, hold while not ready, overrun
      frm_ready = 1'b0;
      got.delete();
      repeat (3) @(negedge clk);
      send_bits(vecs[0].f, 47);
      chk("busy_recv", busy, 1);
      chk("valid_before_end", frm_valid, 0);
      @(negedge clk);
      cmd_i = vecs[0].f[0];
      @(negedge clk);
      cmd_i = 1'b1;
      chk("valid_latency", frm_valid, 1);
      chk("lat_frame", cur(), pk(vecs[0]));
      chk("busy_after", busy, 0);
      repeat (5) @(negedge clk);
      chk("hold_valid", frm_valid, 1);
      base = ovr_cnt;
      send(vecs[1].f);
      @(negedge clk);
      cmd_i = 1'b1;
      repeat (3) @(negedge clk);
      chk("ovr_pulses", 64'(ovr_cnt - base), 64'd1);
      chk("ovr_kept", cur(), pk(vecs[0]));
      chk("ovr_valid", frm_valid, 1);
      frm_ready = 1'b1;
      @(negedge clk);
      frm_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_only("accept", vecs[0]);
      chk("drop_valid", frm_valid, 0);

      // timeout fires 65 cycles after the arm edge
      frm_ready = 1'b1;
      base = tout_cnt;
      @(negedge clk);
      tout_arm = 1'b1;
      @(negedge clk);
      tout_arm = 1'b0;
      a = cyc;
      seen = 1'b0;
      n = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(negedge clk);
         if (tout_err) begin
            seen = 1'b1;
            n = cyc;
         end
      end
      chk("tout_seen", seen, 1);
      chk("tout_delay", 64'(n - a), 64'd65);
      repeat (5) @(negedge clk);
      chk("tout_once", 64'(tout_cnt - base), 64'd1);

      // start bit at sample 40 cancels the timeout
      base = tout_cnt;
      got.delete();
      @(negedge clk);
      tout_arm = 1'b1;
      @(negedge clk);
      tout_arm = 1'b0;
      repeat (38) @(negedge clk);
      send(vecs[0].f);
      @(negedge clk);
      cmd_i = 1'b1;
      repeat (100) @(negedge clk);
      chk("tout_cancel", 64'(tout_cnt - base), 64'd0);
      chk_only("tout_frame", vecs[0]);

      // reset in the middle of a CMD8
      got.delete();
      send_bits(vecs[1].f, 20);
      @(negedge clk);
      rst = 1'b1;
      cmd_i = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      send(vecs[0].f);
      @(negedge clk);
      cmd_i = 1'b1;
      repeat (5) @(negedge clk);
      chk_only("rst_abort", vecs[0]);

      // enable dropped in the middle of a CMD8
      got.delete();
      send_bits(vecs[1].f, 20);
      @(negedge clk);
      en = 1'b0;
      cmd_i = 1'b1;
      repeat (2) @(negedge clk);
      en = 1'b1;
      repeat (3) @(negedge clk);
      send(vecs[0].f);
      @(negedge clk);
      cmd_i = 1'b1;
      repeat (5) @(negedge clk);
      chk_only("en_abort", vecs[0]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
